// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding register-file read / decode.
//
// Holds the architectural PC, issues word fetches to instruction memory over a
// req/ack handshake, and presents {instr, pc, pc+4} to decode under valid/stall
// flow control. A single-entry skid register absorbs a word that returns while
// decode is stalled. Redirects from downstream reload the PC and flush.
//
// Optional feature: define FETCH_CNT_EN to add o_fetch_cnt, a wrapping count of
// instructions consumed by decode.
//
// Ports:
//   i_clk, i_rst          clock (rising edge), asynchronous active-high reset
//   o_imem_req/o_imem_addr fetch request and word byte address (held until ack)
//   i_imem_ack/i_imem_data memory response; data valid when ack=1
//   i_stall               decode cannot accept this cycle
//   i_redirect/_pc        load new PC (low two bits forced to 00) and flush
//   o_valid/o_instr/o_pc/o_pc4  instruction slot presented to decode
//   o_fetch_cnt           consumed-instruction count (FETCH_CNT_EN only)

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_data,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc4
`ifdef FETCH_CNT_EN
    ,
    output logic [CNT_W-1:0] o_fetch_cnt
`endif
);

    localparam logic [1:0] ST_FETCH   = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] disc_addr_q, disc_addr_d;
    logic [31:0] skid_q, skid_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] opc_q, opc_d;
    logic [31:0] opc4_q, opc4_d;

    logic        consume;
    logic        slot_free;
    logic        req;
    logic        ack;
    logic [31:0] redirect_pc_al;
    logic [31:0] pc_inc;

    assign consume        = valid_q & ~i_stall;
    assign slot_free      = ~valid_q | ~i_stall;
    assign req            = (state_q != ST_HOLD);
    assign ack            = req & i_imem_ack;
    assign redirect_pc_al = {i_redirect_pc[31:2], 2'b00};
    assign pc_inc         = pc_q + 32'd4;

    // Low target bits are architecturally ignored.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^i_redirect_pc[1:0];

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        disc_addr_d = disc_addr_q;
        skid_d      = skid_q;
        valid_d     = valid_q;
        instr_d     = instr_q;
        opc_d       = opc_q;
        opc4_d      = opc4_q;

        if (i_redirect) begin
            pc_d    = redirect_pc_al;
            valid_d = 1'b0;
            skid_d  = '0;
            case (state_q)
                ST_FETCH: begin
                    // A request still in flight must be drained before refetching.
                    if (!i_imem_ack) begin
                        state_d     = ST_DISCARD;
                        disc_addr_d = pc_q;
                    end
                end
                ST_HOLD:    state_d = ST_FETCH;
                ST_DISCARD: state_d = ST_DISCARD;
                default:    state_d = ST_FETCH;
            endcase
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (ack) begin
                        pc_d = pc_inc;
                        if (slot_free) begin
                            valid_d = 1'b1;
                            instr_d = i_imem_data;
                            opc_d   = pc_q;
                            opc4_d  = pc_inc;
                        end else begin
                            skid_d  = i_imem_data;
                            state_d = ST_HOLD;
                        end
                    end else if (consume) begin
                        valid_d = 1'b0;
                    end
                end
                ST_HOLD: begin
                    // The skid word sits at pc_q - 4 because pc advanced on capture.
                    if (consume) begin
                        valid_d = 1'b1;
                        instr_d = skid_q;
                        opc_d   = pc_q - 32'd4;
                        opc4_d  = pc_q;
                        state_d = ST_FETCH;
                    end
                end
                ST_DISCARD: begin
                    if (ack) begin
                        state_d = ST_FETCH;
                    end
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_PC;
            disc_addr_q <= '0;
            skid_q      <= '0;
            valid_q     <= 1'b0;
            instr_q     <= '0;
            opc_q       <= '0;
            opc4_q      <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            disc_addr_q <= disc_addr_d;
            skid_q      <= skid_d;
            valid_q     <= valid_d;
            instr_q     <= instr_d;
            opc_q       <= opc_d;
            opc4_q      <= opc4_d;
        end
    end

    assign o_imem_req  = req;
    assign o_imem_addr = (state_q == ST_DISCARD) ? disc_addr_q : pc_q;
    assign o_valid     = valid_q;
    assign o_instr     = instr_q;
    assign o_pc        = opc_q;
    assign o_pc4       = opc4_q;

`ifdef FETCH_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // A flushed slot is not a consume even if decode was ready.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else if (consume && !i_redirect) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_fetch_cnt = cnt_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W == 32'd0);
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int unsigned CNT_W  = 32;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_data;
    logic        i_stall;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_valid;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic [31:0] o_pc4;
`ifdef FETCH_CNT_EN
    logic [CNT_W-1:0] o_fetch_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Memory model controls
    logic        ack_auto;
    logic        ack_man;
    logic        junk_ack;
    int unsigned lat_max;
    int unsigned lat_cnt = 0;
    logic        ovr_en;
    logic [31:0] ovr_a0, ovr_d0, ovr_a1, ovr_d1;

    always #5 i_clk = ~i_clk;

    fetch_unit #(
        .RESET_PC(RST_PC),
        .CNT_W   (CNT_W)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .o_imem_req   (o_imem_req),
        .o_imem_addr  (o_imem_addr),
        .i_imem_ack   (i_imem_ack),
        .i_imem_data  (i_imem_data),
        .i_stall      (i_stall),
        .i_redirect   (i_redirect),
        .i_redirect_pc(i_redirect_pc),
        .o_valid      (o_valid),
        .o_instr      (o_instr),
        .o_pc         (o_pc),
        .o_pc4        (o_pc4)
`ifdef FETCH_CNT_EN
        ,
        .o_fetch_cnt  (o_fetch_cnt)
`endif
    );

    // Memory contents: a bijection of the address, so every word identifies its PC.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h9E37_79B9;
    endfunction

    assign i_imem_data = (ovr_en && o_imem_addr == ovr_a0) ? ovr_d0 :
                         (ovr_en && o_imem_addr == ovr_a1) ? ovr_d1 : word_at(o_imem_addr);
    assign i_imem_ack  = o_imem_req ? (ack_auto ? (lat_cnt == 0) : ack_man) : junk_ack;

    always @(posedge i_clk) begin
        if (o_imem_req && i_imem_ack) lat_cnt <= $urandom_range(lat_max, 0);
        else if (o_imem_req && lat_cnt != 0) lat_cnt <= lat_cnt - 1;
    end

    task automatic test_reset();
        @(negedge i_clk);
        repeat (2) begin
            n_checks++;
            if ({o_valid, o_instr, o_pc, o_pc4} !== 97'd0) begin
                n_fail++;
                $display("FAIL reset_out: got v=%b instr=%h pc=%h pc4=%h want all zero",
                         o_valid, o_instr, o_pc, o_pc4);
            end
            @(negedge i_clk);
        end
        i_rst = 1'b0;
        #1;
        n_checks++;
        if ({o_imem_req, o_imem_addr, o_valid} !== {1'b1, RST_PC, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_req: got req=%b addr=%h v=%b want 1 %h 0",
                     o_imem_req, o_imem_addr, o_valid, RST_PC);
        end
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 6; k++) begin
            logic [31:0] e;
            @(negedge i_clk);
            e = RST_PC + 32'(4 * k);
            n_checks++;
            if ({o_valid, o_pc, o_pc4, o_instr, o_imem_addr} !==
                {1'b1, e, e + 32'd4, word_at(e), e + 32'd4}) begin
                n_fail++;
                $display("FAIL seq_%0d: got v=%b pc=%h pc4=%h instr=%h addr=%h want pc=%h",
                         k, o_valid, o_pc, o_pc4, o_instr, o_imem_addr, e);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] a;
        @(negedge i_clk);
        a = o_imem_addr;
        ovr_a0 = a;          ovr_d0 = 32'hDEAD_BEEF;
        ovr_a1 = a + 32'd4;  ovr_d1 = 32'hFEED_C0DE;
        ovr_en = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(negedge i_clk);
            i_stall = 1'b1;
            n_checks++;
            if ({o_valid, o_instr, o_pc, o_imem_req} !== {1'b1, 32'hDEAD_BEEF, a, s == 0}) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: got v=%b instr=%h pc=%h req=%b want DEADBEEF @%h",
                         s, o_valid, o_instr, o_pc, o_imem_req, a);
            end
        end
        @(negedge i_clk);
        i_stall = 1'b0;
        n_checks++;
        if ({o_valid, o_instr, o_pc, o_imem_req} !== {1'b1, 32'hDEAD_BEEF, a, 1'b0}) begin
            n_fail++;
            $display("FAIL stall_release: got v=%b instr=%h pc=%h req=%b",
                     o_valid, o_instr, o_pc, o_imem_req);
        end
        @(negedge i_clk);
        n_checks++;
        if ({o_valid, o_instr, o_pc, o_pc4, o_imem_req, o_imem_addr} !==
            {1'b1, 32'hFEED_C0DE, a + 32'd4, a + 32'd8, 1'b1, a + 32'd8}) begin
            n_fail++;
            $display("FAIL stall_skid: got v=%b instr=%h pc=%h pc4=%h addr=%h want FEEDC0DE @%h",
                     o_valid, o_instr, o_pc, o_pc4, o_imem_addr, a + 32'd4);
        end
        @(negedge i_clk);
        ovr_en = 1'b0;
        n_checks++;
        if ({o_valid, o_instr, o_pc} !== {1'b1, word_at(a + 32'd8), a + 32'd8}) begin
            n_fail++;
            $display("FAIL stall_next: got v=%b instr=%h pc=%h want pc=%h",
                     o_valid, o_instr, o_pc, a + 32'd8);
        end
    endtask

    task automatic test_redirect_discard();
        logic [31:0] a;
        @(negedge i_clk);
        ack_auto = 1'b0;
        ack_man  = 1'b0;
        a = o_imem_addr;
        for (int m = 1; m <= 3; m++) begin
            @(negedge i_clk);
            i_redirect    = (m == 1);
            i_redirect_pc = 32'h0000_2003;
            ack_man       = (m == 3);
            n_checks++;
            if ({o_imem_req, o_imem_addr, o_valid} !== {1'b1, a, 1'b0}) begin
                n_fail++;
                $display("FAIL disc_wait_%0d: got req=%b addr=%h v=%b want 1 %h 0",
                         m, o_imem_req, o_imem_addr, o_valid, a);
            end
        end
        @(negedge i_clk);
        n_checks++;
        if ({o_imem_req, o_imem_addr, o_valid} !== {1'b1, 32'h0000_2000, 1'b0}) begin
            n_fail++;
            $display("FAIL disc_newreq: got req=%b addr=%h v=%b want 1 00002000 0",
                     o_imem_req, o_imem_addr, o_valid);
        end
        @(negedge i_clk);
        ack_auto = 1'b1;
        n_checks++;
        if ({o_valid, o_pc, o_instr} !== {1'b1, 32'h0000_2000, word_at(32'h0000_2000)}) begin
            n_fail++;
            $display("FAIL disc_first: got v=%b pc=%h instr=%h want pc=00002000",
                     o_valid, o_pc, o_instr);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pcs [3];
        exp_pcs[0] = 32'hFFFF_FFFC;
        exp_pcs[1] = 32'h0000_0000;
        exp_pcs[2] = 32'h0000_0004;
        @(negedge i_clk);
        i_redirect    = 1'b1;
        i_redirect_pc = 32'hFFFF_FFFC;
        @(negedge i_clk);
        i_redirect = 1'b0;
        n_checks++;
        if ({o_valid, o_imem_req, o_imem_addr} !== {1'b0, 1'b1, 32'hFFFF_FFFC}) begin
            n_fail++;
            $display("FAIL wrap_flush: got v=%b req=%b addr=%h want 0 1 fffffffc",
                     o_valid, o_imem_req, o_imem_addr);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            n_checks++;
            if ({o_valid, o_pc, o_pc4, o_instr} !==
                {1'b1, exp_pcs[k], exp_pcs[k] + 32'd4, word_at(exp_pcs[k])}) begin
                n_fail++;
                $display("FAIL wrap_%0d: got v=%b pc=%h pc4=%h want pc=%h",
                         k, o_valid, o_pc, o_pc4, exp_pcs[k]);
            end
        end
    endtask

    task automatic test_reset_hold();
        @(negedge i_clk);
        i_stall = 1'b1;
        @(negedge i_clk);
        n_checks++;
        if ({o_valid, o_imem_req} !== 2'b10) begin
            n_fail++;
            $display("FAIL rsthold_hold: got v=%b req=%b want 1 0", o_valid, o_imem_req);
        end
        i_rst = 1'b1;
        #1;
        n_checks++;
        if ({o_valid, o_pc, o_pc4, o_instr, o_imem_req, o_imem_addr} !==
            {97'd0, 1'b1, RST_PC}) begin
            n_fail++;
            $display("FAIL rsthold_async: got v=%b pc=%h req=%b addr=%h",
                     o_valid, o_pc, o_imem_req, o_imem_addr);
        end
        @(negedge i_clk);
        i_rst   = 1'b0;
        i_stall = 1'b0;
        @(negedge i_clk);
        n_checks++;
        if ({o_valid, o_pc, o_instr} !== {1'b1, RST_PC, word_at(RST_PC)}) begin
            n_fail++;
            $display("FAIL rsthold_refetch: got v=%b pc=%h instr=%h want pc=%h",
                     o_valid, o_pc, o_instr, RST_PC);
        end
    endtask

`ifdef FETCH_CNT_EN
    task automatic test_fetch_cnt();
        int cnt;
        int k;
        cnt = 0;
        k   = 0;
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        n_checks++;
        if (o_fetch_cnt !== '0) begin
            n_fail++;
            $display("FAIL cnt_reset: got %0d want 0", o_fetch_cnt);
        end
        while (cnt < 10 && k < 40) begin
            @(negedge i_clk);
            i_stall       = (k == 3 || k == 4);
            i_redirect    = (k == 6);
            i_redirect_pc = 32'h0000_0300;
            if (o_valid && !i_stall && !i_redirect) cnt++;
            k++;
        end
        @(negedge i_clk);
        i_stall    = 1'b1;
        i_redirect = 1'b0;
        n_checks++;
        if (o_fetch_cnt !== CNT_W'(10) || cnt != 10) begin
            n_fail++;
            $display("FAIL cnt_ten: got %0d want 10 (model %0d)", o_fetch_cnt, cnt);
        end
        @(negedge i_clk);
        i_stall = 1'b0;
    endtask
`endif

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] prev_addr;
        logic        expect_flush, prev_hold, prev_pending;
        int          n_cons;
        int          cnt;
        @(negedge i_clk);
        i_rst = 1'b1;
        i_stall = 1'b0;
        i_redirect = 1'b0;
        @(negedge i_clk);
        i_rst    = 1'b0;
        lat_max  = 3;
        exp_pc   = RST_PC;
        expect_flush = 1'b0;
        prev_hold    = 1'b0;
        prev_pending = 1'b0;
        prev_addr    = '0;
        n_cons = 0;
        cnt    = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge i_clk);
            if (expect_flush) begin
                n_checks++;
                if (o_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rnd_flush c=%0d: got v=%b want 0", c, o_valid);
                end
            end
            if (o_valid === 1'b1) begin
                n_checks++;
                if ({o_pc, o_pc4, o_instr} !== {exp_pc, exp_pc + 32'd4, word_at(exp_pc)}) begin
                    n_fail++;
                    $display("FAIL rnd_out c=%0d: got pc=%h pc4=%h instr=%h want pc=%h instr=%h",
                             c, o_pc, o_pc4, o_instr, exp_pc, word_at(exp_pc));
                end
            end
            if (prev_hold) begin
                n_checks++;
                if (o_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rnd_stall_hold c=%0d: got v=%b want 1", c, o_valid);
                end
            end
            if (prev_pending) begin
                n_checks++;
                if ({o_imem_req, o_imem_addr} !== {1'b1, prev_addr}) begin
                    n_fail++;
                    $display("FAIL rnd_req_stable c=%0d: got req=%b addr=%h want 1 %h",
                             c, o_imem_req, o_imem_addr, prev_addr);
                end
            end
            if (o_imem_req === 1'b1) begin
                n_checks++;
                if (o_imem_addr[1:0] !== 2'b00) begin
                    n_fail++;
                    $display("FAIL rnd_align c=%0d: got addr=%h", c, o_imem_addr);
                end
            end
`ifdef FETCH_CNT_EN
            n_checks++;
            if (o_fetch_cnt !== CNT_W'(cnt)) begin
                n_fail++;
                $display("FAIL rnd_cnt c=%0d: got %0d want %0d", c, o_fetch_cnt, cnt);
            end
`endif
            i_stall       = ($urandom_range(99, 0) < 30);
            i_redirect    = ($urandom_range(99, 0) < 6);
            i_redirect_pc = ($urandom_range(3, 0) == 0) ?
                            (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
            junk_ack      = $urandom_range(1, 0) == 1;
            #1;
            if (i_redirect) begin
                exp_pc       = {i_redirect_pc[31:2], 2'b00};
                expect_flush = 1'b1;
            end else begin
                expect_flush = 1'b0;
                if (o_valid && !i_stall) begin
                    exp_pc = exp_pc + 32'd4;
                    cnt++;
                    n_cons++;
                end
            end
            prev_hold    = o_valid && i_stall && !i_redirect;
            prev_pending = o_imem_req && !i_imem_ack;
            prev_addr    = o_imem_addr;
        end
        i_stall    = 1'b0;
        i_redirect = 1'b0;
        junk_ack   = 1'b0;
        n_checks++;
        if (n_cons < 300) begin
            n_fail++;
            $display("FAIL rnd_progress: got %0d consumes want at least 300", n_cons);
        end
    endtask

    initial begin
        i_rst         = 1'b1;
        i_stall       = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = '0;
        ack_auto      = 1'b1;
        ack_man       = 1'b0;
        junk_ack      = 1'b0;
        lat_max       = 0;
        ovr_en        = 1'b0;
        ovr_a0 = '0; ovr_d0 = '0; ovr_a1 = '0; ovr_d1 = '0;

        test_reset();
        test_sequential();
        test_stall();
        test_redirect_discard();
        test_wrap();
        test_reset_hold();
`ifdef FETCH_CNT_EN
        test_fetch_cnt();
`endif
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of register-file read/decode.
- Holds the architectural PC and issues word fetches to instruction memory over a req/ack handshake.
- Presents instruction, its PC and PC+4 to decode with valid/stall flow control.
- Accepts branch/jump redirects from downstream; consumes the next-PC value selected by the datapath muxes.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 00
CNT_W, 32, width of fetch counter (optional feature only)

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  asynchronous active-high reset
o_imem_req  output  1  fetch request to instruction memory
o_imem_addr  output  32  byte address of requested word
i_imem_ack  input  1  memory returns data this cycle
i_imem_data  input  32  instruction word, valid when i_imem_ack=1
i_stall  input  1  decode cannot accept this cycle
i_redirect  input  1  load new PC and flush
i_redirect_pc  input  32  redirect target; bits [1:0] ignored (forced 00)
o_valid  output  1  o_instr/o_pc/o_pc4 hold a live instruction
o_instr  output  32  fetched instruction
o_pc  output  32  address of o_instr
o_pc4  output  32  o_pc + 4
o_fetch_cnt  output  CNT_W  retired-fetch count (only with FETCH_CNT_EN)

Behaviour:
- One clock domain; all state updates on rising i_clk; i_rst clears asynchronously.
- Reset values: pc=RESET_PC, state=FETCH, o_valid=0, o_instr=0, o_pc=0, o_pc4=0, skid empty, o_fetch_cnt=0. o_imem_req=1 and o_imem_addr=RESET_PC immediately after reset deassertion.
- Consume: output slot consumed on a cycle where o_valid=1 and i_stall=0. Slot is free if o_valid=0 or consumed.
- Memory protocol: o_imem_req and o_imem_addr held stable from assertion until the cycle i_imem_ack=1. Ack with req=0 is ignored. Latency ≥0 cycles (same-cycle ack allowed).
- States:
  - FETCH: req=1, addr=pc. On ack with slot free: load output regs (o_instr=data, o_pc=pc, o_pc4=pc+4, o_valid=1), pc<=pc+4, stay FETCH. On ack with slot not free: store data in the single-entry skid register, pc<=pc+4, go HOLD. If no ack and slot consumed: o_valid<=0.
  - HOLD: req=0. When the slot is consumed, skid moves to the output regs, then go FETCH.
  - DISCARD: req=1, addr held at the abandoned address. On ack, drop the data, then go FETCH at the new pc.
- Redirect (highest priority, any state):
  - pc<=i_redirect_pc with [1:0]=00.
  - o_valid<=0 and skid cleared next cycle.
  - If in FETCH with req=1 and no ack this cycle: go DISCARD.
  - If ack in the same cycle: data dropped, go FETCH.
  - From HOLD: go FETCH.
- Redirect during DISCARD updates pc only; remains in DISCARD.
- Redirect and stall in the same cycle: redirect wins; the output is flushed regardless of stall.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Throughput: one instruction per cycle with zero-latency ack and no stall. First o_valid appears 1 cycle after the first ack.
- Outputs are held stable while o_valid=1 and i_stall=1.
- Reset mid-operation: immediate return to reset values; any outstanding memory ack after reset is treated as the response to the new RESET_PC request.

Optional Feature:
- Macro FETCH_CNT_EN. Defined: o_fetch_cnt increments by 1 on every consume cycle (valid & !stall, no redirect that cycle), wraps at 2^CNT_W, and clears on reset.
- Undefined: port and counter absent; no other behaviour change.

Test Plan:
- Reset with RESET_PC=32'h0000_0100, ack tied 1 -> o_imem_addr=0x100 then 0x104, 0x108; o_pc=0x100, o_pc4=0x104 one cycle after the first ack; o_valid continuous.
- i_stall=1 for 3 cycles while data 32'hDEADBEEF is valid and the next ack returns 32'hFEEDC0DE -> o_instr holds DEADBEEF, req drops (HOLD); on stall release DEADBEEF is consumed then FEEDC0DE appears; no word lost or duplicated.
- Ack delayed 3 cycles, i_redirect=1 with i_redirect_pc=32'h0000_2003 in cycle 1 of the wait -> addr held at the old value until ack, data dropped, next req addr=0x2000, o_valid=0 meanwhile.
- Redirect to 32'hFFFF_FFFC, ack every cycle -> o_pc sequence FFFF_FFFC, 0000_0000, 0000_0004.
- Assert i_rst for 1 cycle mid-stream while in HOLD -> o_valid=0 immediately, skid discarded, next req addr=RESET_PC.
- With FETCH_CNT_EN, 10 consumes including 2 stall cycles and 1 redirect -> o_fetch_cnt=10; stalled and flushed cycles are not counted.
